// File: rtl/router_pkg.sv
// Shared definitions for the parametrised router controller: the 4-bit state
// encoding (also used by the bench) and the default port count.
package router_pkg;

  localparam int DEFAULT_NUM_PORTS = 3;

  localparam logic [3:0] S_DECODE = 4'd0;
  localparam logic [3:0] S_LFD    = 4'd1;
  localparam logic [3:0] S_LD     = 4'd2;
  localparam logic [3:0] S_FFS    = 4'd3;
  localparam logic [3:0] S_LAF    = 4'd4;
  localparam logic [3:0] S_LP     = 4'd5;
  localparam logic [3:0] S_CPE    = 4'd6;
  localparam logic [3:0] S_WTE    = 4'd7;
  localparam logic [3:0] S_DROP   = 4'd8;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = S_DECODE,
    LOAD_FIRST_DATA    = S_LFD,
    LOAD_DATA          = S_LD,
    FIFO_FULL_STATE    = S_FFS,
    LOAD_AFTER_FULL    = S_LAF,
    LOAD_PARITY        = S_LP,
    CHECK_PARITY_ERROR = S_CPE,
    WAIT_TILL_EMPTY    = S_WTE,
    DROP_PACKET        = S_DROP
  } state_t;

endpackage

// File: rtl/router_fsm_np.sv
// Control FSM for an N-output-port packet router. Decodes the header address,
// sequences header/payload/parity loading into the selected output FIFO,
// stalls while that FIFO is full, honours per-port soft resets and discards
// packets addressed to a port that does not exist (counting them).
//
// Source handshake: the source presents one byte per cycle while pkt_valid is
// high and drops pkt_valid together with the parity byte. There is no ready
// signal; the source must hold its byte whenever busy is high, and a byte is
// accepted on every clock edge where pkt_valid is high and busy is low.
module router_fsm_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 write_enb_reg,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 laf_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic                 drop_state,
  output logic [ADDR_W-1:0]    dest_addr,
  output logic [CNT_W-1:0]     drop_count,
  output logic [3:0]           fsm_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   addr_valid;
  logic   hdr_empty;
  logic   dest_empty;
  logic   sr_hit;

  // Select one per-port flag by address; out-of-range addresses read as 0.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] vec,
                                    input logic [ADDR_W-1:0]    idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(idx) == i) r = vec[i];
    end
    return r;
  endfunction

  // Header address checks and the soft reset aimed at the current packet.
  always_comb begin
    addr_valid = (int'(data_in) < NUM_PORTS);
    hdr_empty  = port_bit(fifo_empty, data_in);
    dest_empty = port_bit(fifo_empty, dest_addr);
    sr_hit     = port_bit(soft_reset, dest_addr);
  end

  // State register, latched destination and saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= DECODE_ADDRESS;
      dest_addr  <= '0;
      drop_count <= '0;
    end else begin
      // A soft reset is meaningless before a destination is chosen or while
      // the packet is being thrown away, so it only acts in the load states.
      if (sr_hit && state != DECODE_ADDRESS && state != DROP_PACKET) begin
        state <= DECODE_ADDRESS;
      end else begin
        case (state)
          DECODE_ADDRESS: begin
            if (pkt_valid) begin
              if (!addr_valid)    state <= DROP_PACKET;
              else if (hdr_empty) state <= LOAD_FIRST_DATA;
              else                state <= WAIT_TILL_EMPTY;
            end
          end
          LOAD_FIRST_DATA: state <= LOAD_DATA;
          LOAD_DATA: begin
            if (fifo_full)       state <= FIFO_FULL_STATE;
            else if (!pkt_valid) state <= LOAD_PARITY;
          end
          FIFO_FULL_STATE: begin
            if (!fifo_full) state <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)           state <= DECODE_ADDRESS;
            else if (low_packet_valid) state <= LOAD_PARITY;
            else                       state <= LOAD_DATA;
          end
          LOAD_PARITY: state <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: begin
            if (fifo_full) state <= FIFO_FULL_STATE;
            else           state <= DECODE_ADDRESS;
          end
          WAIT_TILL_EMPTY: begin
            if (dest_empty) state <= LOAD_FIRST_DATA;
          end
          DROP_PACKET: begin
            if (!pkt_valid) state <= DECODE_ADDRESS;
          end
          default: state <= DECODE_ADDRESS;
        endcase
      end

      // The destination tracks the header on every valid decode cycle, even
      // for packets that end up dropped.
      if (state == DECODE_ADDRESS && pkt_valid) begin
        dest_addr <= data_in;
        if (!addr_valid && drop_count != '1) begin
          drop_count <= drop_count + CNT_ONE;
        end
      end
    end
  end

  // State decodes, valid in the same cycle the state is occupied.
  always_comb begin
    write_enb_reg = 1'b0;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    laf_state     = 1'b0;
    ld_state      = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    drop_state    = 1'b0;
    case (state)
      DECODE_ADDRESS:     detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        busy          = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        busy          = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      WAIT_TILL_EMPTY:    busy = 1'b1;
      DROP_PACKET:        drop_state = 1'b1;
      default:            detect_add = 1'b0;
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np. Two instances: a 4-port one with an 8-bit
// drop counter and a 3-port one with a 2-bit counter (so addresses can be
// invalid and the counter saturates quickly). Each stimulus cycle pushes the
// hand-derived expected state plus the stimulus it saw; one compare process
// checks every output against a model that derives the state decodes from a
// table and tracks dest_addr / drop_count from the header rules.
module tb_router_fsm_np;
  import router_pkg::*;

  // entry = {sel, state[3:0], pv, din[1:0], rst, pin, pin_dest[1:0], pin_cnt[7:0]}
  localparam int W = 20;

  logic       clock = 1'b0;
  logic       rst4, rst3, sel;
  logic       pv, ff, pd, lpv;
  logic [1:0] din;
  logic [3:0] fe, sr;

  wire [8:0]  dec4, dec3;
  wire [1:0]  dest4, dest3;
  wire [7:0]  cnt4;
  wire [1:0]  cnt3;
  wire [3:0]  st4, st3;

  logic [W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  // Clock/reset block.
  always #5 clock = ~clock;

  router_fsm_np #(.NUM_PORTS(4), .CNT_W(8)) u_dut4 (
    .clock(clock), .reset(rst4), .pkt_valid(pv), .data_in(din),
    .fifo_full(ff), .fifo_empty(fe), .soft_reset(sr),
    .parity_done(pd), .low_packet_valid(lpv),
    .write_enb_reg(dec4[1]), .detect_add(dec4[8]), .lfd_state(dec4[7]),
    .laf_state(dec4[5]), .ld_state(dec4[6]), .full_state(dec4[4]),
    .rst_int_reg(dec4[3]), .busy(dec4[2]), .drop_state(dec4[0]),
    .dest_addr(dest4), .drop_count(cnt4), .fsm_state(st4)
  );

  router_fsm_np #(.NUM_PORTS(3), .CNT_W(2)) u_dut3 (
    .clock(clock), .reset(rst3), .pkt_valid(pv), .data_in(din),
    .fifo_full(ff), .fifo_empty(fe[2:0]), .soft_reset(sr[2:0]),
    .parity_done(pd), .low_packet_valid(lpv),
    .write_enb_reg(dec3[1]), .detect_add(dec3[8]), .lfd_state(dec3[7]),
    .laf_state(dec3[5]), .ld_state(dec3[6]), .full_state(dec3[4]),
    .rst_int_reg(dec3[3]), .busy(dec3[2]), .drop_state(dec3[0]),
    .dest_addr(dest3), .drop_count(cnt3), .fsm_state(st3)
  );

  // Output table per state:
  // {detect_add, lfd, ld, laf, full, rst_int, busy, write_enb, drop}
  function automatic logic [8:0] spec_dec(input logic [3:0] s);
    case (s)
      S_DECODE: return 9'b100000000;
      S_LFD:    return 9'b010000100;
      S_LD:     return 9'b001000010;
      S_LAF:    return 9'b000100110;
      S_FFS:    return 9'b000010100;
      S_LP:     return 9'b000000110;
      S_CPE:    return 9'b000001100;
      S_WTE:    return 9'b000000100;
      S_DROP:   return 9'b000000001;
      default:  return 9'b000000000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard: one expected entry per cycle, checked on the falling edge.
  logic [1:0] m_dest [2] = '{2'd0, 2'd0};
  int         m_cnt  [2] = '{0, 0};

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      int           s, np, cmax;
      logic [3:0]   est;
      e    = exp_q.pop_front();
      s    = int'(e[19]);
      est  = e[18:15];
      np   = (s == 1) ? 3 : 4;
      cmax = (s == 1) ? 3 : 255;
      if (s == 1) begin
        check("state", int'(st3), int'(est));
        check("decodes", int'(dec3), int'(spec_dec(est)));
        check("dest_addr", int'(dest3), int'(m_dest[1]));
        check("drop_count", int'(cnt3), m_cnt[1]);
      end else begin
        check("state", int'(st4), int'(est));
        check("decodes", int'(dec4), int'(spec_dec(est)));
        check("dest_addr", int'(dest4), int'(m_dest[0]));
        check("drop_count", int'(cnt4), m_cnt[0]);
      end
      if (e[10]) begin
        check("model_dest_pin", int'(m_dest[s]), int'(e[9:8]));
        check("model_cnt_pin", m_cnt[s], int'(e[7:0]));
      end
      // Advance the model with the rules for what this cycle's edge does.
      if (e[11]) begin
        m_dest[s] = 2'd0;
        m_cnt[s]  = 0;
      end else if (est == S_DECODE && e[14]) begin
        m_dest[s] = e[13:12];
        if (int'(e[13:12]) >= np && m_cnt[s] < cmax) m_cnt[s] = m_cnt[s] + 1;
      end
    end
  end

  // Driver tasks: record the expected state for the current cycle, then
  // advance to just after the next rising edge.
  task automatic tick(input logic [3:0] st, input logic pin,
                      input logic [1:0] pdest, input logic [7:0] pcnt);
    exp_q.push_back({sel, st, pv, din, (sel ? rst3 : rst4), pin, pdest, pcnt});
    @(posedge clock);
    #1;
  endtask

  task automatic t(input logic [3:0] st);
    tick(st, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic tp(input logic [3:0] st, input logic [1:0] pdest, input logic [7:0] pcnt);
    tick(st, 1'b1, pdest, pcnt);
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1; sel = 1'b0;
    pv = 1'b0; ff = 1'b0; pd = 1'b0; lpv = 1'b0;
    din = 2'd0; fe = 4'd0; sr = 4'd0;
    @(posedge clock);
    #1;
    rst4 = 1'b0;

    // ---- 4-port instance ----
    tp(S_DECODE, 2'd0, 8'd0);

    // Packet to port 2, empty FIFO, 4 payload cycles (last carries parity).
    pv = 1'b1; din = 2'd2; fe = 4'b0100;
    t(S_DECODE); t(S_LFD); t(S_LD); t(S_LD); t(S_LD);
    pv = 1'b0;
    t(S_LD); t(S_LP); t(S_CPE);
    tp(S_DECODE, 2'd2, 8'd0);

    // Port 1 busy for five cycles, then full stall with low_packet_valid.
    pv = 1'b1; din = 2'd1; fe = 4'b0000;
    t(S_DECODE);
    for (int i = 0; i < 4; i++) t(S_WTE);
    fe = 4'b0010;
    t(S_WTE); t(S_LFD);
    ff = 1'b1;
    t(S_LD); t(S_FFS); t(S_FFS);
    ff = 1'b0; lpv = 1'b1; pv = 1'b0;
    t(S_FFS); t(S_LAF);
    lpv = 1'b0;
    t(S_LP); t(S_CPE);
    tp(S_DECODE, 2'd1, 8'd0);

    // LAF back to LD, CPE into full stall, parity_done beats low_packet_valid.
    pv = 1'b1; din = 2'd0; fe = 4'b0001;
    t(S_DECODE); t(S_LFD);
    ff = 1'b1; t(S_LD);
    ff = 1'b0; t(S_FFS);
    t(S_LAF);
    pv = 1'b0; t(S_LD);
    ff = 1'b1; t(S_LP); t(S_CPE);
    ff = 1'b0; t(S_FFS);
    pd = 1'b1; lpv = 1'b1; t(S_LAF);
    pd = 1'b0; lpv = 1'b0;
    tp(S_DECODE, 2'd0, 8'd0);

    // Soft resets: ignored in DECODE, ignored for other ports, honoured for dest.
    pv = 1'b1; din = 2'd1; fe = 4'b0010; sr = 4'b0011;
    t(S_DECODE);
    sr = 4'b0000; t(S_LFD);
    sr = 4'b0001; t(S_LD);
    sr = 4'b0010; t(S_LD);
    sr = 4'b0000; pv = 1'b0;
    tp(S_DECODE, 2'd1, 8'd0);

    // Soft reset while waiting for an empty FIFO.
    pv = 1'b1; din = 2'd2; fe = 4'b0000;
    t(S_DECODE);
    sr = 4'b0100; t(S_WTE);
    sr = 4'b0000; pv = 1'b0;
    tp(S_DECODE, 2'd2, 8'd0);

    // Reset mid-packet.
    pv = 1'b1; din = 2'd3; fe = 4'b1000;
    t(S_DECODE); t(S_LFD);
    rst4 = 1'b1; t(S_LD);
    rst4 = 1'b0; pv = 1'b0;
    tp(S_DECODE, 2'd0, 8'd0);

    // ---- 3-port instance, 2-bit drop counter ----
    sel = 1'b1; rst4 = 1'b1; rst3 = 1'b0;
    tp(S_DECODE, 2'd0, 8'd0);

    pv = 1'b1; din = 2'd3;
    t(S_DECODE); t(S_DROP); t(S_DROP);
    pv = 1'b0; t(S_DROP);
    tp(S_DECODE, 2'd3, 8'd1);

    for (int i = 0; i < 4; i++) begin
      pv = 1'b1; din = 2'd3; t(S_DECODE);
      pv = 1'b0; t(S_DROP);
    end
    tp(S_DECODE, 2'd3, 8'd3);

    // Soft reset does not clear the drop counter.
    pv = 1'b1; din = 2'd1; fe = 4'b0010;
    t(S_DECODE); t(S_LFD);
    sr = 4'b0010; t(S_LD);
    sr = 4'b0000; pv = 1'b0;
    tp(S_DECODE, 2'd1, 8'd3);

    // Reset mid-packet clears destination and counter; counting restarts.
    pv = 1'b1; din = 2'd2; fe = 4'b0100;
    t(S_DECODE); t(S_LFD);
    rst3 = 1'b1; t(S_LD);
    rst3 = 1'b0; pv = 1'b0;
    tp(S_DECODE, 2'd0, 8'd0);
    pv = 1'b1; din = 2'd3; t(S_DECODE);
    pv = 1'b0; t(S_DROP);
    tp(S_DECODE, 2'd3, 8'd1);

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
